bin_to_bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the per-digit 7-segment decoders. Each 4-bit output nibble drives one decoder input.
- Optional leading-zero blanking emits nibble 4'hF, which the decoder renders as a blank digit.
- Start/busy/done handshake, so a counter or ALU result can be converted once and held for display.

---
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD digits for the 7-segment decoders.
// One shift-add-3 iteration per clock. The result register holds its value between conversions.
module bin_to_bcd_seq #(
  parameter int BIN_W    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  // state | meaning
  // IDLE  | waiting for start; the cycle after DONE is also spent here with done=1, busy=1
  // SHIFT | one add-3/shift iteration per cycle, BIN_W iterations in total
  // DONE  | iterations finished; the next edge publishes scratch into bcd

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int VW    = BIN_W + 4;
  localparam logic [BCD_W-1:0] RST_BCD = (BLANK_LZ != 0) ? ({BCD_W{1'b1}} << 4) : '0;

  function automatic int dec_digits_needed();
    logic [VW-1:0] v;
    int n;
    v = {4'b0000, {BIN_W{1'b1}}};
    n = 0;
    while (v != '0) begin
      v = v / VW'(10);
      n++;
    end
    return n;
  endfunction

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be at least 1");
  end
  if (DIGITS < dec_digits_needed()) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold 2^BIN_W-1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   blanked;
  logic [CNT_W-1:0]   cnt;
  logic               lead;

  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // Units digit is never blanked, so the scan stops at digit 1.
  always_comb begin
    blanked = scratch;
    lead    = 1'b1;
    if (BLANK_LZ != 0) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && scratch[4*k +: 4] == 4'd0) blanked[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= RST_BCD;
      sr      <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr      <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          scratch <= {adj[BCD_W-2:0], sr[BIN_W-1]};
          sr      <= sr << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          bcd   <= blanked;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (plain and leading-zero blanked) against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
  localparam int BIN_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;
  logic        busy0, done0, busy1, done1;
  logic [15:0] bcd0, bcd1;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit checking = 1'b0;

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(0)) d0 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy0), .done(done0), .bcd(bcd0));
  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy1), .done(done1), .bcd(bcd1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v, input bit blank);
    logic [15:0] r;
    bit lead;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if (blank) begin
      lead = 1'b1;
      for (int k = 3; k >= 1; k--) begin
        if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Model: t counts edges since the accepting edge, -1 when idle.
  int          t = -1;
  int          val = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_bcd0 = 16'h0000, m_bcd1 = 16'hFFF0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = -1; m_busy = 1'b0; m_done = 1'b0;
      m_bcd0 = 16'h0000; m_bcd1 = 16'hFFF0;
    end else begin
      if (t < 0 || t == BIN_W + 1) begin
        if (start) begin val = int'(bin); t = 0; end
        else t = -1;
      end else begin
        t++;
      end
      m_busy = (t >= 0);
      m_done = (t == BIN_W + 1);
      if (m_done) begin
        m_bcd0 = to_bcd(val, 1'b0);
        m_bcd1 = to_bcd(val, 1'b1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (checking) begin
      check("busy0", 16'(busy0), 16'(m_busy));
      check("done0", 16'(done0), 16'(m_done));
      check("bcd0", bcd0, m_bcd0);
      check("busy1", 16'(busy1), 16'(m_busy));
      check("done1", 16'(done1), 16'(m_done));
      check("bcd1", bcd1, m_bcd1);
      if (done0) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [9:0] v);
    @(negedge clk);
    bin = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int dc;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    #1;
    check("rst_busy", 16'(busy0), 16'h0);
    check("rst_done", 16'(done0), 16'h0);
    check("rst_bcd0", bcd0, 16'h0000);
    check("rst_bcd1", bcd1, 16'hFFF0);

    // 999: latency pinned edge by edge
    go(10'd999);
    check("999_busyN", 16'(busy0), 16'h1);
    step(10);
    check("999_doneN10", 16'(done0), 16'h0);
    check("999_bcdN10", bcd0, 16'h0000);
    step(1);
    check("999_doneN11", 16'(done0), 16'h1);
    check("999_bcdN11", bcd0, 16'h0999);
    check("999_busyN11", 16'(busy0), 16'h1);
    step(1);
    check("999_busyN12", 16'(busy0), 16'h0);
    check("999_doneN12", 16'(done0), 16'h0);

    go(10'd1023);
    step(11);
    check("1023_bcd0", bcd0, 16'h1023);
    check("1023_bcd1", bcd1, 16'h1023);
    step(1);
    go(10'd0);
    step(10);
    check("zero_held", bcd0, 16'h1023);
    step(1);
    check("zero_bcd0", bcd0, 16'h0000);
    check("zero_bcd1", bcd1, 16'hFFF0);
    check("zero_done", 16'(done0), 16'h1);
    step(1);

    go(10'd7);    step(12); check("blank7", bcd1, 16'hFFF7);
    go(10'd305);  step(12); check("blank305", bcd1, 16'hF305);
    go(10'd1000); step(12); check("blank1000", bcd1, 16'h1000);
    go(10'd999);  step(12); check("prev999", bcd0, 16'h0999);

    // start during busy is ignored
    dc = done_cnt;
    go(10'd42);
    step(3);
    @(negedge clk);
    bin = 10'd500;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    step(6);
    check("ign_hold", bcd0, 16'h0999);
    step(1);
    check("ign_bcd", bcd0, 16'h0042);
    step(14);
    check("ign_done_pulses", 16'(done_cnt - dc), 16'd1);

    // async reset mid-conversion
    go(10'd999);
    step(4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 16'(busy0), 16'h0);
    check("arst_done", 16'(done0), 16'h0);
    check("arst_bcd0", bcd0, 16'h0000);
    check("arst_bcd1", bcd1, 16'hFFF0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    step(14);
    check("arst_no_done", 16'(done_cnt - dc), 16'd0);
    go(10'd123);
    step(11);
    check("after_rst_bcd0", bcd0, 16'h0123);
    check("after_rst_bcd1", bcd1, 16'hF123);
    step(2);

    // start held high: restart every BIN_W+2 edges
    @(negedge clk);
    bin = 10'd256;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", 16'(done0), 16'((i == 11) || (i == 23)));
      if (i == 11 || i == 23) check("hold_bcd", bcd0, 16'h0256);
    end
    @(negedge clk);
    start = 1'b0;
    step(14);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: bin = 10'd0;
        1: bin = 10'd1023;
        2: bin = 10'd999;
        default: bin = 10'($urandom_range(0, 1023));
      endcase
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    step(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
